tag_multicaster: RTL and testbench
==================================

TAG_MULTICASTER -- requirements
Module: tag_multicaster

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, ifmap/fltr word width (psum is 2*DATA_WIDTH); NUM_COL, 4, columns on bus (ID_W = max(1,$clog2(NUM_COL))); FIFO_DEPTH, 4, per-column beat buffer depth (power of 2, >=2).
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 cfg_id  in  ID_W  static column ID of this instance.
REQ-006 bus_valid / bus_ready  in / out  1 / 1  bus-side beat handshake.
REQ-007 bus_tag, bus_bcast, bus_ch_en  in  ID_W, 1, 3  destination column, broadcast flag, channel-valid mask {psum,fltr,ifmap}.
REQ-008 bus_ifmap, bus_fltr, bus_psum  in  DW, DW, 2*DW  beat payload.
REQ-009 kernel_load, kernel_size_in  in  1, 8  kernel-size config strobe and value.
REQ-010 pe_valid / pe_ready  out / in  1 / 1  PE-side beat handshake.
REQ-011 pe_ifmap, pe_fltr, pe_psum, pe_ch_en  out  DW, DW, 2*DW, 3  head beat to PE.
REQ-012 pe_kernel_size  out  8  latched kernel size.
REQ-013 pe_opsum_valid / pe_opsum_ready, pe_opsum  in / out, in  1/1, 2*DW  PE result return.
REQ-014 bus_opsum_valid / bus_opsum_ready, bus_opsum, bus_opsum_id  out / in, out, out  1/1, 2*DW, ID_W  result to bus, tagged with cfg_id.
REQ-015 beat_cnt  out  16  matched beats accepted, saturating.

Function
REQ-016 match SHALL be bus_bcast OR (bus_tag == cfg_id), combinational.
REQ-017 bus_ready SHALL be (NOT match) OR (NOT fifo_full); non-matching beats are accepted and discarded so a column never stalls a bus it is not addressed by.
REQ-018 A matching beat accepted on cycle N SHALL be written to FIFO and visible at pe_valid/pe_* on cycle N+1 (first-word-fall-through).
REQ-019 bus_ready SHALL depend only on full, not on a same-cycle pop; full FIFO blocks matching beats even when pe_ready is high.
REQ-020 Simultaneous push and pop when neither full nor empty SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 pe_valid SHALL equal NOT empty; pe_* SHALL hold stable while pe_valid and NOT pe_ready.
REQ-022 Beats with bus_ch_en == 3'b000 SHALL be accepted and dropped, not counted.
REQ-023 beat_cnt SHALL increment on every stored beat and saturate at 16'hFFFF.
REQ-024 pe_kernel_size SHALL load kernel_size_in on kernel_load; concurrent beat traffic unaffected.
REQ-025 Return path SHALL be a 1-entry skid register: pe_opsum_ready = NOT held OR bus_opsum_ready; bus_opsum_valid = held; capture on pe_opsum_valid AND pe_opsum_ready.
REQ-026 Return path SHALL sustain one result per cycle when bus_opsum_ready stays high; result latency 1 cycle.
REQ-027 bus_opsum_id SHALL equal cfg_id at all times.

Reset
REQ-028 On rst: FIFO pointers and count 0, pe_valid 0, bus_opsum_valid 0, beat_cnt 0, pe_kernel_size 0; in-flight beats discarded.
REQ-029 rst SHALL override any same-cycle push, pop, kernel_load or capture.
REQ-030 FIFO payload storage SHALL need no reset.

Structure
REQ-031 Package mc_pkg SHALL hold channel index constants (CH_IFMAP=0, CH_FLTR=1, CH_PSUM=2), NUM_CH=3, and the packed beat struct (ch_en, ifmap, fltr, psum) parametrised by DATA_WIDTH via localparam widths.
REQ-032 One sub-module mc_sync_fifo (parametrised width/depth, FWFT, full/empty) SHALL implement the beat buffer.

Verification
REQ-033 cfg_id=2, beats tag=2 x3, pe_ready=1 -> three beats on PE at N+1 each, beat_cnt=3.
REQ-034 cfg_id=2, tag=1 bcast=0 -> bus_ready=1, pe_valid stays 0, beat_cnt=0; same beat with bcast=1 -> delivered.
REQ-035 pe_ready=0, 5 matching beats, DEPTH=4 -> bus_ready low after 4th, 5th held; pe_ready=1 -> all 5 delivered in order.
REQ-036 bus_opsum_ready=0, PE sends 32'hDEAD_BEEF then 32'h1234_5678 -> first held, pe_opsum_ready=0; release -> both in order, id=cfg_id.
REQ-037 rst asserted with 3 beats buffered and kernel_size=9 -> next cycle pe_valid=0, beat_cnt=0, pe_kernel_size=0.
REQ-038 Force beat_cnt to 16'hFFFE, send 3 beats -> beat_cnt ends 16'hFFFF.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - channel constants and beat layout shared by the tag multicaster
package mc_pkg;
   localparam int CH_IFMAP = 0;
   localparam int CH_FLTR  = 1;
   localparam int CH_PSUM  = 2;
   localparam int NUM_CH   = 3;

   localparam int MC_DATA_WIDTH = 16;
   localparam int MC_PSUM_WIDTH = 2 * MC_DATA_WIDTH;

   typedef struct packed {
      logic [NUM_CH-1:0]        ch_en;
      logic [MC_DATA_WIDTH-1:0] ifmap;
      logic [MC_DATA_WIDTH-1:0] fltr;
      logic [MC_PSUM_WIDTH-1:0] psum;
   } beat_t;

   localparam int BEAT_W = $bits(beat_t);
endpackage

// File: rtl/mc_sync_fifo.sv
// rtl/mc_sync_fifo.sv - first-word-fall-through synchronous FIFO with full/empty
module mc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign dout  = mem[rd_ptr_q];

   always_comb begin
      do_push  = push & ~full;
      do_pop   = pop & ~empty;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/tag_multicaster.sv
// rtl/tag_multicaster.sv - per-column tag filter, beat buffer and result skid register
module tag_multicaster
   import mc_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int ID_W      = (NUM_COL > 2) ? $clog2(NUM_COL) : 1,
   localparam int PW        = 2 * DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ID_W-1:0]       cfg_id,
   input  logic                  bus_valid,
   output logic                  bus_ready,
   input  logic [ID_W-1:0]       bus_tag,
   input  logic                  bus_bcast,
   input  logic [2:0]            bus_ch_en,
   input  logic [DATA_WIDTH-1:0] bus_ifmap,
   input  logic [DATA_WIDTH-1:0] bus_fltr,
   input  logic [PW-1:0]         bus_psum,
   input  logic                  kernel_load,
   input  logic [7:0]            kernel_size_in,
   output logic                  pe_valid,
   input  logic                  pe_ready,
   output logic [DATA_WIDTH-1:0] pe_ifmap,
   output logic [DATA_WIDTH-1:0] pe_fltr,
   output logic [PW-1:0]         pe_psum,
   output logic [2:0]            pe_ch_en,
   output logic [7:0]            pe_kernel_size,
   input  logic                  pe_opsum_valid,
   output logic                  pe_opsum_ready,
   input  logic [PW-1:0]         pe_opsum,
   output logic                  bus_opsum_valid,
   input  logic                  bus_opsum_ready,
   output logic [PW-1:0]         bus_opsum,
   output logic [ID_W-1:0]       bus_opsum_id,
   output logic [15:0]           beat_cnt
);
   logic        match, store, pop, capture;
   logic        fifo_full, fifo_empty;
   beat_t       wr_beat, rd_beat;
   logic [15:0] beat_cnt_q, beat_cnt_d;
   logic [7:0]  kernel_size_q, kernel_size_d;
   logic        held_q, held_d;
   logic [PW-1:0] opsum_q, opsum_d;

   always_comb begin
      match     = bus_bcast | (bus_tag == cfg_id);
      // Unaddressed beats are always sunk so this column never stalls the bus.
      bus_ready = ~match | ~fifo_full;
      store     = bus_valid & bus_ready & match &
                  (bus_ch_en[CH_IFMAP] | bus_ch_en[CH_FLTR] | bus_ch_en[CH_PSUM]);
      wr_beat   = '{ch_en: bus_ch_en, ifmap: bus_ifmap, fltr: bus_fltr, psum: bus_psum};

      pe_valid  = ~fifo_empty;
      pop       = pe_valid & pe_ready;
      pe_ch_en  = rd_beat.ch_en;
      pe_ifmap  = rd_beat.ifmap;
      pe_fltr   = rd_beat.fltr;
      pe_psum   = rd_beat.psum;

      beat_cnt_d = beat_cnt_q;
      if (store && beat_cnt_q != 16'hFFFF) beat_cnt_d = beat_cnt_q + 16'd1;

      kernel_size_d = kernel_load ? kernel_size_in : kernel_size_q;

      pe_opsum_ready = ~held_q | bus_opsum_ready;
      capture        = pe_opsum_valid & pe_opsum_ready;
      held_d         = held_q;
      opsum_d        = opsum_q;
      if (capture) begin
         held_d  = 1'b1;
         opsum_d = pe_opsum;
      end else if (bus_opsum_ready) begin
         held_d  = 1'b0;
      end
   end

   assign beat_cnt        = beat_cnt_q;
   assign pe_kernel_size  = kernel_size_q;
   assign bus_opsum_valid = held_q;
   assign bus_opsum       = opsum_q;
   assign bus_opsum_id    = cfg_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt_q    <= '0;
         kernel_size_q <= '0;
         held_q        <= 1'b0;
         opsum_q       <= '0;
      end else begin
         beat_cnt_q    <= beat_cnt_d;
         kernel_size_q <= kernel_size_d;
         held_q        <= held_d;
         opsum_q       <= opsum_d;
      end
   end

   mc_sync_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_beat_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (store),
      .din   (wr_beat),
      .pop   (pop),
      .dout  (rd_beat),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_tag_multicaster.sv
// tb/tb_tag_multicaster.sv - scoreboard bench for tag_multicaster
module tb_tag_multicaster;
   localparam int DW  = 16;
   localparam int IDW = 2;
   localparam int PW  = 32;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [IDW-1:0] cfg_id = 2'd2;
   logic           bus_valid = 1'b0;
   logic           bus_ready;
   logic [IDW-1:0] bus_tag = '0;
   logic           bus_bcast = 1'b0;
   logic [2:0]     bus_ch_en = '0;
   logic [DW-1:0]  bus_ifmap = '0;
   logic [DW-1:0]  bus_fltr = '0;
   logic [PW-1:0]  bus_psum = '0;
   logic           kernel_load = 1'b0;
   logic [7:0]     kernel_size_in = '0;
   logic           pe_valid;
   logic           pe_ready = 1'b0;
   logic [DW-1:0]  pe_ifmap;
   logic [DW-1:0]  pe_fltr;
   logic [PW-1:0]  pe_psum;
   logic [2:0]     pe_ch_en;
   logic [7:0]     pe_kernel_size;
   logic           pe_opsum_valid = 1'b0;
   logic           pe_opsum_ready;
   logic [PW-1:0]  pe_opsum = '0;
   logic           bus_opsum_valid;
   logic           bus_opsum_ready = 1'b0;
   logic [PW-1:0]  bus_opsum;
   logic [IDW-1:0] bus_opsum_id;
   logic [15:0]    beat_cnt;

   typedef struct packed {
      logic [2:0]    ch;
      logic [DW-1:0] ifm;
      logic [DW-1:0] flt;
      logic [PW-1:0] ps;
   } exp_beat_t;

   exp_beat_t     beat_q[$];
   logic [PW-1:0] opsum_q[$];
   int            exp_cnt = 0;
   int            total = 0;
   int            bad = 0;

   always #5 clk = ~clk;

   tag_multicaster #(.DATA_WIDTH(DW), .NUM_COL(4), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .cfg_id(cfg_id),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_tag(bus_tag), .bus_bcast(bus_bcast),
      .bus_ch_en(bus_ch_en), .bus_ifmap(bus_ifmap), .bus_fltr(bus_fltr), .bus_psum(bus_psum),
      .kernel_load(kernel_load), .kernel_size_in(kernel_size_in),
      .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr),
      .pe_psum(pe_psum), .pe_ch_en(pe_ch_en), .pe_kernel_size(pe_kernel_size),
      .pe_opsum_valid(pe_opsum_valid), .pe_opsum_ready(pe_opsum_ready), .pe_opsum(pe_opsum),
      .bus_opsum_valid(bus_opsum_valid), .bus_opsum_ready(bus_opsum_ready),
      .bus_opsum(bus_opsum), .bus_opsum_id(bus_opsum_id), .beat_cnt(beat_cnt)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   // Mid-cycle sample point: pops and compares every beat/result transferred at the next edge.
   task automatic sample();
      exp_beat_t e, got;
      logic [PW-1:0] eo;
      @(negedge clk);
      if (!rst && pe_valid && pe_ready) begin
         total++;
         got = {pe_ch_en, pe_ifmap, pe_fltr, pe_psum};
         if (beat_q.size() == 0) begin
            bad++;
            $display("FAIL pe_beat: got %h, required no beat (scoreboard empty)", got);
         end else begin
            e = beat_q.pop_front();
            if (got !== e) begin
               bad++;
               $display("FAIL pe_beat: got %h, required %h", got, e);
            end
         end
      end
      if (!rst && bus_opsum_valid && bus_opsum_ready) begin
         total++;
         if (opsum_q.size() == 0) begin
            bad++;
            $display("FAIL bus_opsum: got %h, required no result (scoreboard empty)", bus_opsum);
         end else begin
            eo = opsum_q.pop_front();
            if (bus_opsum !== eo || bus_opsum_id !== cfg_id) begin
               bad++;
               $display("FAIL bus_opsum: got %h id %0d, required %h id %0d", bus_opsum, bus_opsum_id, eo, cfg_id);
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      sample();
      step();
   endtask

   task automatic drive_beat(input logic [IDW-1:0] tag, input logic bc, input logic [2:0] ch,
                             input logic [DW-1:0] ifm, input logic [DW-1:0] flt,
                             input logic [PW-1:0] ps, input logic stored);
      bus_valid = 1'b1;
      bus_tag   = tag;
      bus_bcast = bc;
      bus_ch_en = ch;
      bus_ifmap = ifm;
      bus_fltr  = flt;
      bus_psum  = ps;
      if (stored) begin
         beat_q.push_back({ch, ifm, flt, ps});
         if (exp_cnt < 65535) exp_cnt++;
      end
   endtask

   task automatic test_reset();
      step();
      step();
      sample();
      total++;
      if (pe_valid !== 1'b0 || bus_opsum_valid !== 1'b0 || beat_cnt !== 16'd0 ||
          pe_kernel_size !== 8'd0 || bus_opsum_id !== cfg_id) begin
         bad++;
         $display("FAIL reset_state: got pe_valid=%b opsum_valid=%b cnt=%0d ks=%0d id=%0d, required 0 0 0 0 %0d",
                  pe_valid, bus_opsum_valid, beat_cnt, pe_kernel_size, bus_opsum_id, cfg_id);
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_basic();
      pe_ready = 1'b1;
      drive_beat(2'd2, 1'b0, 3'b111, 16'h1111, 16'h2222, 32'hA000_0001, 1'b1);
      sample();
      total++;
      if (bus_ready !== 1'b1) begin bad++; $display("FAIL basic_ready: got %b, required 1", bus_ready); end
      step();
      drive_beat(2'd2, 1'b0, 3'b001, 16'h3333, 16'h4444, 32'hA000_0002, 1'b1);
      sample();
      total++;
      if (pe_valid !== 1'b1) begin bad++; $display("FAIL basic_n1_a: got pe_valid=%b, required 1", pe_valid); end
      step();
      drive_beat(2'd2, 1'b0, 3'b100, 16'h5555, 16'h6666, 32'hA000_0003, 1'b1);
      sample();
      total++;
      if (pe_valid !== 1'b1) begin bad++; $display("FAIL basic_n1_b: got pe_valid=%b, required 1", pe_valid); end
      step();
      bus_valid = 1'b0;
      sample();
      total++;
      if (pe_valid !== 1'b1) begin bad++; $display("FAIL basic_n1_c: got pe_valid=%b, required 1", pe_valid); end
      step();
      sample();
      total++;
      if (pe_valid !== 1'b0 || beat_cnt !== 16'd3 || beat_q.size() != 0) begin
         bad++;
         $display("FAIL basic_done: got pe_valid=%b cnt=%0d left=%0d, required 0 3 0", pe_valid, beat_cnt, beat_q.size());
      end
      step();
   endtask

   task automatic test_filter();
      drive_beat(2'd1, 1'b0, 3'b111, 16'h0BAD, 16'h0BAD, 32'h0BAD_0BAD, 1'b0);
      sample();
      total++;
      if (bus_ready !== 1'b1) begin bad++; $display("FAIL filter_ready: got %b, required 1", bus_ready); end
      step();
      bus_valid = 1'b0;
      sample();
      total++;
      if (pe_valid !== 1'b0 || beat_cnt !== exp_cnt[15:0]) begin
         bad++;
         $display("FAIL filter_drop: got pe_valid=%b cnt=%0d, required 0 %0d", pe_valid, beat_cnt, exp_cnt);
      end
      step();
      drive_beat(2'd1, 1'b1, 3'b111, 16'h0BAD, 16'h0BAD, 32'h0BAD_0BAD, 1'b1);
      tick();
      bus_valid = 1'b0;
      sample();
      total++;
      if (beat_cnt !== exp_cnt[15:0] || beat_q.size() != 0) begin
         bad++;
         $display("FAIL filter_bcast: got cnt=%0d left=%0d, required %0d 0", beat_cnt, beat_q.size(), exp_cnt);
      end
      step();
      drive_beat(2'd2, 1'b0, 3'b000, 16'hFACE, 16'hFACE, 32'hFACE_FACE, 1'b0);
      sample();
      total++;
      if (bus_ready !== 1'b1) begin bad++; $display("FAIL chen0_ready: got %b, required 1", bus_ready); end
      step();
      bus_valid = 1'b0;
      sample();
      total++;
      if (pe_valid !== 1'b0 || beat_cnt !== exp_cnt[15:0]) begin
         bad++;
         $display("FAIL chen0_drop: got pe_valid=%b cnt=%0d, required 0 %0d", pe_valid, beat_cnt, exp_cnt);
      end
      step();
   endtask

   task automatic test_full();
      pe_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive_beat(2'd2, 1'b0, 3'b010, 16'h5000 + 16'(i), 16'h6000 + 16'(i), 32'h7000_0000 + i, 1'b1);
         sample();
         total++;
         if (bus_ready !== (i < 4)) begin
            bad++;
            $display("FAIL full_ready_%0d: got %b, required %b", i, bus_ready, (i < 4));
         end
         if (i < 4) step();
      end
      step();
      sample();
      total++;
      if (bus_ready !== 1'b0 || pe_valid !== 1'b1 || pe_ifmap !== 16'h5000) begin
         bad++;
         $display("FAIL full_hold: got ready=%b pe_valid=%b ifmap=%h, required 0 1 5000", bus_ready, pe_valid, pe_ifmap);
      end
      step();
      bus_tag = 2'd1;
      sample();
      total++;
      if (bus_ready !== 1'b1) begin bad++; $display("FAIL full_other_tag: got %b, required 1", bus_ready); end
      step();
      bus_tag = 2'd2;
      pe_ready = 1'b1;
      sample();
      total++;
      if (bus_ready !== 1'b0) begin bad++; $display("FAIL full_no_bypass: got %b, required 0", bus_ready); end
      step();
      sample();
      total++;
      if (bus_ready !== 1'b1) begin bad++; $display("FAIL full_release: got %b, required 1", bus_ready); end
      step();
      bus_valid = 1'b0;
      repeat (6) tick();
      total++;
      if (beat_q.size() != 0 || beat_cnt !== exp_cnt[15:0]) begin
         bad++;
         $display("FAIL full_drain: got left=%0d cnt=%0d, required 0 %0d", beat_q.size(), beat_cnt, exp_cnt);
      end
   endtask

   task automatic test_opsum_backpressure();
      bus_opsum_ready = 1'b0;
      pe_opsum_valid  = 1'b1;
      pe_opsum        = 32'hDEAD_BEEF;
      opsum_q.push_back(32'hDEAD_BEEF);
      sample();
      total++;
      if (pe_opsum_ready !== 1'b1) begin bad++; $display("FAIL opsum_empty_ready: got %b, required 1", pe_opsum_ready); end
      step();
      pe_opsum = 32'h1234_5678;
      opsum_q.push_back(32'h1234_5678);
      for (int k = 0; k < 2; k++) begin
         sample();
         total++;
         if (bus_opsum_valid !== 1'b1 || bus_opsum !== 32'hDEAD_BEEF || pe_opsum_ready !== 1'b0) begin
            bad++;
            $display("FAIL opsum_held_%0d: got valid=%b data=%h pe_ready=%b, required 1 deadbeef 0",
                     k, bus_opsum_valid, bus_opsum, pe_opsum_ready);
         end
         step();
      end
      bus_opsum_ready = 1'b1;
      sample();
      total++;
      if (pe_opsum_ready !== 1'b1) begin bad++; $display("FAIL opsum_release_ready: got %b, required 1", pe_opsum_ready); end
      step();
      pe_opsum_valid = 1'b0;
      tick();
      sample();
      total++;
      if (bus_opsum_valid !== 1'b0 || opsum_q.size() != 0) begin
         bad++;
         $display("FAIL opsum_drain: got valid=%b left=%0d, required 0 0", bus_opsum_valid, opsum_q.size());
      end
      step();
   endtask

   task automatic test_opsum_stream();
      bus_opsum_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pe_opsum_valid = 1'b1;
         pe_opsum = 32'hC0DE_0000 + i;
         opsum_q.push_back(32'hC0DE_0000 + i);
         sample();
         total++;
         if (pe_opsum_ready !== 1'b1) begin
            bad++;
            $display("FAIL stream_ready_%0d: got %b, required 1", i, pe_opsum_ready);
         end
         step();
      end
      pe_opsum_valid = 1'b0;
      tick();
      total++;
      if (opsum_q.size() != 0) begin
         bad++;
         $display("FAIL stream_drain: got left=%0d, required 0", opsum_q.size());
      end
   endtask

   task automatic test_reset_flush();
      pe_ready = 1'b0;
      bus_opsum_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_beat(2'd2, 1'b0, 3'b011, 16'h9000 + 16'(i), 16'h9100, 32'h9200_0000, 1'b1);
         tick();
      end
      bus_valid = 1'b0;
      kernel_load = 1'b1;
      kernel_size_in = 8'd9;
      pe_opsum_valid = 1'b1;
      pe_opsum = 32'h5A5A_5A5A;
      opsum_q.push_back(32'h5A5A_5A5A);
      tick();
      kernel_load = 1'b0;
      pe_opsum_valid = 1'b0;
      sample();
      total++;
      if (pe_kernel_size !== 8'd9 || pe_valid !== 1'b1 || bus_opsum_valid !== 1'b1) begin
         bad++;
         $display("FAIL prerst_state: got ks=%0d pe_valid=%b opsum_valid=%b, required 9 1 1",
                  pe_kernel_size, pe_valid, bus_opsum_valid);
      end
      step();
      rst = 1'b1;
      drive_beat(2'd2, 1'b0, 3'b111, 16'hEEEE, 16'hEEEE, 32'hEEEE_EEEE, 1'b0);
      kernel_load = 1'b1;
      kernel_size_in = 8'd5;
      pe_opsum_valid = 1'b1;
      tick();
      beat_q.delete();
      opsum_q.delete();
      exp_cnt = 0;
      sample();
      total++;
      if (pe_valid !== 1'b0 || beat_cnt !== 16'd0 || pe_kernel_size !== 8'd0 || bus_opsum_valid !== 1'b0) begin
         bad++;
         $display("FAIL rst_flush: got pe_valid=%b cnt=%0d ks=%0d opsum_valid=%b, required 0 0 0 0",
                  pe_valid, beat_cnt, pe_kernel_size, bus_opsum_valid);
      end
      step();
      rst = 1'b0;
      bus_valid = 1'b0;
      kernel_load = 1'b0;
      pe_opsum_valid = 1'b0;
      step();
      sample();
      total++;
      if (pe_valid !== 1'b0 || pe_kernel_size !== 8'd0) begin
         bad++;
         $display("FAIL rst_release: got pe_valid=%b ks=%0d, required 0 0", pe_valid, pe_kernel_size);
      end
      step();
   endtask

   task automatic test_saturate();
      pe_ready = 1'b1;
      for (int i = 0; i < 65534; i++) begin
         drive_beat(2'd2, 1'b0, 3'b100, i[15:0], ~i[15:0], i, 1'b1);
         tick();
      end
      bus_valid = 1'b0;
      tick();
      sample();
      total++;
      if (beat_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_near: got %h, required fffe", beat_cnt); end
      step();
      for (int i = 0; i < 3; i++) begin
         drive_beat(2'd3, 1'b1, 3'b001, 16'hF000 + 16'(i), 16'h0F0F, 32'hF0F0_F0F0, 1'b1);
         tick();
      end
      bus_valid = 1'b0;
      tick();
      sample();
      total++;
      if (beat_cnt !== 16'hFFFF || beat_q.size() != 0) begin
         bad++;
         $display("FAIL sat_top: got cnt=%h left=%0d, required ffff 0", beat_cnt, beat_q.size());
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_filter();
      test_full();
      test_opsum_backpressure();
      test_opsum_stream();
      test_reset_flush();
      test_saturate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
